// File: rtl/codon_pkg.sv
// Shared types and limits for the codon writer/reader/counter family.
// A codon is three 2-bit nucleotides, first nucleotide in the top bits.
package codon_pkg;

    parameter int MAX_CODONS = 5;

    typedef enum logic [1:0] {
        NUC_A = 2'b00,
        NUC_C = 2'b01,
        NUC_G = 2'b10,
        NUC_T = 2'b11
    } nucleotide_t;

    // n0 occupies [5:4], n1 [3:2], n2 [1:0]
    typedef struct packed {
        nucleotide_t n0;
        nucleotide_t n1;
        nucleotide_t n2;
    } codon_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE0,
        ST_WRITE1,
        ST_WRITE2,
        ST_DONE
    } writer_state_t;

endpackage

// File: rtl/codon_writer.sv
// Accepts codons over a valid/ready handshake and writes them one nucleotide
// per cycle into a sequence memory, stopping on the last codon or at MAX_CODONS.
module codon_writer
    import codon_pkg::*;
#(
    parameter int MAX_CODONS = codon_pkg::MAX_CODONS,
    parameter int ADDR_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        codon_in,
    input  logic              codon_valid,
    input  logic              codon_last,
    output logic              codon_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_data,
    output logic [ADDR_W-1:0] seq_length,
    output logic [2:0]        codon_total,
    output logic              done_writer
);

    writer_state_t     state_q, state_d;
    codon_t            codon_q, codon_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        total_q, total_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            codon_q <= '0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            codon_q <= codon_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            total_q <= total_d;
        end
    end

    // The address counter doubles as the nucleotide count, so seq_length is always 3*codon_total at DONE.
    always_comb begin
        state_d = state_q;
        codon_d = codon_q;
        last_d  = last_q;
        addr_d  = addr_q;
        total_d = total_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ACCEPT;
                    addr_d  = '0;
                    total_d = '0;
                end
            end
            ST_ACCEPT: begin
                if (codon_valid) begin
                    codon_d = codon_t'(codon_in);
                    last_d  = codon_last;
                    total_d = total_q + 3'd1;
                    state_d = ST_WRITE0;
                end
            end
            ST_WRITE0: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = ST_WRITE1;
            end
            ST_WRITE1: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = ST_WRITE2;
            end
            ST_WRITE2: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_q || (total_q == 3'(MAX_CODONS))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        codon_ready = (state_q == ST_ACCEPT);
        done_writer = (state_q == ST_DONE);
        seq_length  = addr_q;
        codon_total = total_q;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_data    = 2'b00;
        case (state_q)
            ST_WRITE0: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
                mem_data = codon_q.n0;
            end
            ST_WRITE1: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
                mem_data = codon_q.n1;
            end
            ST_WRITE2: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
                mem_data = codon_q.n2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_codon_writer.sv
// Directed checks of codon_writer: reset, handshake, nucleotide writes,
// overflow at MAX_CODONS, stalls, mid-write reset, ignored starts, back-to-back.
module tb_codon_writer;

    logic       clock;
    logic       reset;
    logic       start;
    logic [5:0] codon_in;
    logic       codon_valid;
    logic       codon_last;
    logic       codon_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [1:0] mem_data;
    logic [3:0] seq_length;
    logic [2:0] codon_total;
    logic       done_writer;

    int errors = 0;
    int checks = 0;

    codon_writer #(.MAX_CODONS(5), .ADDR_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .codon_in    (codon_in),
        .codon_valid (codon_valid),
        .codon_last  (codon_last),
        .codon_ready (codon_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .seq_length  (seq_length),
        .codon_total (codon_total),
        .done_writer (done_writer)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        codon_valid = 1'b1;
        step();
        checks++;
        if ({mem_we, mem_addr, mem_data, codon_ready, done_writer, seq_length, codon_total} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {mem_we, mem_addr, mem_data, codon_ready, done_writer, seq_length, codon_total});
        end
        step();
        checks++;
        if (codon_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_priority_ready: got %b expected 0", codon_ready);
        end
        reset = 1'b0;
        start = 1'b0;
        codon_valid = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [5:0] tbl [2] = '{6'b000110, 6'b111001};
        logic [5:0] cw;
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({codon_ready, mem_we} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL basic_accept%0d: got ready/we=%b expected 10", k, {codon_ready, mem_we});
            end
            cw = tbl[k];
            codon_in = cw;
            codon_last = (k == 1);
            codon_valid = 1'b1;
            step();
            codon_valid = 1'b0;
            codon_last = 1'b0;
            for (int n = 0; n < 3; n++) begin
                checks++;
                if ({mem_we, mem_addr, mem_data} !== {1'b1, 4'(k * 3 + n), cw[5 - 2 * n -: 2]}) begin
                    errors++;
                    $display("[TB] FAIL basic_write%0d: got we/addr/data=%b/%0d/%b expected 1/%0d/%b",
                             k * 3 + n, mem_we, mem_addr, mem_data, k * 3 + n, cw[5 - 2 * n -: 2]);
                end
                step();
            end
        end
        checks++;
        if ({done_writer, seq_length, codon_total, mem_we, codon_ready} !== {1'b1, 4'd6, 3'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_done: got done/len/total=%b/%0d/%0d expected 1/6/2",
                     done_writer, seq_length, codon_total);
        end
    endtask

    task automatic test_overflow();
        logic [5:0] tbl [5] = '{6'b000110, 6'b011011, 6'b100111, 6'b110001, 6'b001110};
        logic [5:0] cw;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (codon_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ovf_ready%0d: got %b expected 1", k, codon_ready);
            end
            cw = tbl[k];
            codon_in = cw;
            codon_last = 1'b0;
            codon_valid = 1'b1;
            step();
            codon_valid = 1'b0;
            for (int n = 0; n < 3; n++) begin
                checks++;
                if ({mem_we, mem_addr, mem_data} !== {1'b1, 4'(k * 3 + n), cw[5 - 2 * n -: 2]}) begin
                    errors++;
                    $display("[TB] FAIL ovf_write%0d: got we/addr/data=%b/%0d/%b expected 1/%0d/%b",
                             k * 3 + n, mem_we, mem_addr, mem_data, k * 3 + n, cw[5 - 2 * n -: 2]);
                end
                step();
            end
        end
        checks++;
        if ({done_writer, seq_length, codon_total} !== {1'b1, 4'd15, 3'd5}) begin
            errors++;
            $display("[TB] FAIL ovf_done: got done/len/total=%b/%0d/%0d expected 1/15/5",
                     done_writer, seq_length, codon_total);
        end
        codon_in = 6'b101010;
        codon_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({codon_ready, mem_we, done_writer, codon_total} !== {1'b0, 1'b0, 1'b1, 3'd5}) begin
                errors++;
                $display("[TB] FAIL ovf_sixth%0d: got ready/we/done/total=%b/%b/%b/%0d expected 0/0/1/5",
                         c, codon_ready, mem_we, done_writer, codon_total);
            end
            step();
        end
        codon_valid = 1'b0;
    endtask

    task automatic test_stall();
        pulse_start();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({codon_ready, mem_we, seq_length, codon_total} !== {1'b1, 1'b0, 4'd0, 3'd0}) begin
                errors++;
                $display("[TB] FAIL stall%0d: got ready/we/len/total=%b/%b/%0d/%0d expected 1/0/0/0",
                         c, codon_ready, mem_we, seq_length, codon_total);
            end
            step();
        end
        codon_in = 6'b010101;
        codon_last = 1'b1;
        codon_valid = 1'b1;
        step();
        codon_valid = 1'b0;
        codon_last = 1'b0;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if ({mem_we, mem_addr, mem_data} !== {1'b1, 4'(n), 2'b01}) begin
                errors++;
                $display("[TB] FAIL stall_write%0d: got we/addr/data=%b/%0d/%b expected 1/%0d/01",
                         n, mem_we, mem_addr, mem_data, n);
            end
            step();
        end
        checks++;
        if ({done_writer, seq_length, codon_total} !== {1'b1, 4'd3, 3'd1}) begin
            errors++;
            $display("[TB] FAIL stall_done: got done/len/total=%b/%0d/%0d expected 1/3/1",
                     done_writer, seq_length, codon_total);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        codon_in = 6'b000000;
        codon_valid = 1'b1;
        step();
        codon_valid = 1'b0;
        step();
        step();
        step();
        codon_in = 6'b110110;
        codon_valid = 1'b1;
        step();
        codon_valid = 1'b0;
        step();
        checks++;
        if ({mem_we, mem_addr, mem_data} !== {1'b1, 4'd4, 2'b01}) begin
            errors++;
            $display("[TB] FAIL mid_write1: got we/addr/data=%b/%0d/%b expected 1/4/01",
                     mem_we, mem_addr, mem_data);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_data, codon_ready, done_writer, seq_length, codon_total} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got %h expected 0",
                     {mem_we, mem_addr, mem_data, codon_ready, done_writer, seq_length, codon_total});
        end
        step();
        checks++;
        if ({mem_we, codon_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mid_reset_idle: got we/ready=%b expected 00", {mem_we, codon_ready});
        end
        pulse_start();
        codon_in = 6'b100100;
        codon_last = 1'b1;
        codon_valid = 1'b1;
        step();
        codon_valid = 1'b0;
        codon_last = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_data} !== {1'b1, 4'd0, 2'b10}) begin
            errors++;
            $display("[TB] FAIL mid_restart: got we/addr/data=%b/%0d/%b expected 1/0/10",
                     mem_we, mem_addr, mem_data);
        end
        step();
        step();
        step();
    endtask

    task automatic test_start_ignored();
        pulse_start();
        codon_in = 6'b011100;
        codon_valid = 1'b1;
        step();
        codon_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_data, codon_total} !== {1'b1, 4'd1, 2'b11, 3'd1}) begin
            errors++;
            $display("[TB] FAIL start_in_write: got we/addr/data/total=%b/%0d/%b/%0d expected 1/1/11/1",
                     mem_we, mem_addr, mem_data, codon_total);
        end
        step();
        step();
        codon_in = 6'b111111;
        codon_last = 1'b1;
        codon_valid = 1'b1;
        step();
        codon_valid = 1'b0;
        codon_last = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_data} !== {1'b1, 4'd3, 2'b11}) begin
            errors++;
            $display("[TB] FAIL start_addr_cont: got we/addr/data=%b/%0d/%b expected 1/3/11",
                     mem_we, mem_addr, mem_data);
        end
        step();
        step();
        step();
        checks++;
        if ({done_writer, seq_length, codon_total} !== {1'b1, 4'd6, 3'd2}) begin
            errors++;
            $display("[TB] FAIL start_done: got done/len/total=%b/%0d/%0d expected 1/6/2",
                     done_writer, seq_length, codon_total);
        end
        pulse_start();
        checks++;
        if ({done_writer, seq_length, codon_total, codon_ready} !== {1'b0, 4'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL start_from_done: got done/len/total/ready=%b/%0d/%0d/%b expected 0/0/0/1",
                     done_writer, seq_length, codon_total, codon_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] tbl [3] = '{6'b001001, 6'b110011, 6'b011110};
        logic [5:0] cw;
        int ph;
        int cod;
        codon_valid = 1'b1;
        cw = tbl[0];
        for (int c = 0; c < 12; c++) begin
            ph = c % 4;
            cod = c / 4;
            checks++;
            if (codon_ready !== (ph == 0)) begin
                errors++;
                $display("[TB] FAIL b2b_ready%0d: got %b expected %b", c, codon_ready, (ph == 0));
            end
            if (ph == 0) begin
                cw = tbl[cod];
                codon_in = cw;
                codon_last = (cod == 2);
            end else begin
                checks++;
                if ({mem_we, mem_addr, mem_data} !== {1'b1, 4'(cod * 3 + ph - 1), cw[7 - 2 * ph -: 2]}) begin
                    errors++;
                    $display("[TB] FAIL b2b_write%0d: got we/addr/data=%b/%0d/%b expected 1/%0d/%b",
                             c, mem_we, mem_addr, mem_data, cod * 3 + ph - 1, cw[7 - 2 * ph -: 2]);
                end
            end
            step();
        end
        codon_valid = 1'b0;
        codon_last = 1'b0;
        checks++;
        if ({done_writer, seq_length, codon_total, codon_ready} !== {1'b1, 4'd9, 3'd3, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_done: got done/len/total/ready=%b/%0d/%0d/%b expected 1/9/3/0",
                     done_writer, seq_length, codon_total, codon_ready);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        codon_in = 6'd0;
        codon_valid = 1'b0;
        codon_last = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/codon_writer.md
CODON_WRITER -- requirements
Module: codon_writer

Interface
REQ-001 Parameter MAX_CODONS, default 5: maximum codons written per sequence.
REQ-002 Parameter ADDR_W, default 4: sequence-memory address width; must satisfy 2^ADDR_W >= 3*MAX_CODONS.
REQ-003 Ports SHALL be exactly as in REQ-004 to REQ-016. One clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a new sequence.
REQ-007 codon_in  input  6  codon to write, as nucleotides [5:4],[3:2],[1:0]; encoding A=00, C=01, G=10, T=11.
REQ-008 codon_valid  input  1  codon_in is valid this cycle.
REQ-009 codon_last  input  1  qualifies codon_in as the final codon of the sequence.
REQ-010 codon_ready  output  1  writer accepts a codon this cycle.
REQ-011 mem_we  output  1  sequence-memory write enable.
REQ-012 mem_addr  output  ADDR_W  nucleotide address.
REQ-013 mem_data  output  2  nucleotide written.
REQ-014 seq_length  output  ADDR_W  nucleotides written in the current/last sequence.
REQ-015 codon_total  output  3  codons accepted in the current/last sequence.
REQ-016 done_writer  output  1  sequence complete; held until next start or reset.

Function
REQ-017 FSM states: IDLE, ACCEPT, WRITE0, WRITE1, WRITE2, DONE.
REQ-018 IDLE or DONE, start=1 -> ACCEPT next cycle; seq_length, codon_total, and the address counter clear to 0; done_writer clears to 0.
REQ-019 start in ACCEPT or WRITE0-2: ignored.
REQ-020 codon_ready = 1 only in ACCEPT; combinational from state.
REQ-021 Handshake: codon_valid & codon_ready in a cycle -> latch codon_in and codon_last, codon_total += 1, go to WRITE0.
REQ-022 codon_valid=0 in ACCEPT: remain in ACCEPT indefinitely, with no writes.
REQ-023 WRITE0/1/2: mem_we=1; mem_data = latched codon [5:4]/[3:2]/[1:0] respectively; mem_addr = address counter; counter and seq_length += 1 after each write.
REQ-024 Latency: first nucleotide write occurs the cycle after the handshake; 3 consecutive write cycles per codon; next acceptance no earlier than the cycle after WRITE2.
REQ-025 After WRITE2: go to DONE if latched last=1 or codon_total == MAX_CODONS; otherwise go to ACCEPT.
REQ-026 Overflow: the MAX_CODONS-th codon ends the sequence even if codon_last=0; no further codon_ready until the next start.
REQ-027 mem_we=0 and mem_addr/mem_data=0 in IDLE, ACCEPT, DONE.
REQ-028 done_writer=1 exactly in DONE.
REQ-029 seq_length always equals 3*codon_total once a sequence is in DONE; the counters never wrap within a sequence.

Reset
REQ-030 reset=1 at a clock edge -> IDLE, all outputs 0, counters 0, latched codon 0; this takes priority over start and handshake.
REQ-031 Reset mid-WRITE: no write in the reset cycle or after it; the partial sequence is abandoned.

Structure
REQ-032 Shared package codon_pkg: nucleotide_t (2-bit enum A/C/G/T), codon_t (3 x nucleotide_t, packed 6 bits), writer_state_t, MAX_CODONS constant shared with codon_reader/codon_counter.
REQ-033 No sub-module: FSM, nucleotide mux, and counters live in one module; single always_ff for state and counters, always_comb for outputs.

Verification
REQ-034 Reset then start, codons 6'b000110 (ACG) then 6'b111001 (TGC, last=1) -> writes at addr 0-5 of data 00,01,10,11,10,01; done_writer=1; seq_length=6; codon_total=2.
REQ-035 Start, then 6 valid codons with last=0 -> exactly 5 accepted; 15 writes (addr 0-14); done after the 5th; codon_ready=0 while the 6th is offered.
REQ-036 codon_valid held low 10 cycles in ACCEPT -> mem_we=0, state unchanged; then valid 6'b010101 with last=1 -> 3 writes of 01 to addr 0-2, then done.
REQ-037 Reset asserted in WRITE1 of the 2nd codon -> next cycle: all outputs 0, no mem_we; a new start restarts at addr 0.
REQ-038 start pulsed during WRITE0 -> ignored, addressing continues; start in DONE -> done_writer drops the next cycle, counters 0.
REQ-039 Back-to-back valid held high with 3 codons -> one acceptance every 4 cycles; codon_ready high only in ACCEPT cycles.
